issue_ctrl: RTL and testbench

In-order issue controller between the decode stage and execute. Holds a register scoreboard and a long-latency (mul/div) unit occupancy counter, and sequences a fixed-length squash window after a branch redirect. Each cycle it decides whether the decoded instruction may issue, and drives the decode-stage stall and flush.

---
 rtl/issue_ctrl_pkg.sv | 15 +
 rtl/issue_ctrl_scoreboard.sv | 50 +++++
 rtl/issue_ctrl.sv | 126 ++++++++++++
 tb/tb_issue_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared constants and types for the in-order issue controller.
package issue_ctrl_pkg;

  localparam int WORD          = 32;
  localparam int DEF_NREG      = 32;
  localparam int DEF_REGW      = 5;
  localparam int DEF_LONG_LAT  = 8;
  localparam int DEF_FLUSH_CYC = 2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Register scoreboard: pending-write vector, set/clear update and
// three-port hazard lookup with same-cycle writeback release.
module issue_ctrl_scoreboard #(
  parameter int NREG = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_v,
  input  logic [REGW-1:0] wb_rd,
  input  logic            set_v,
  input  logic [REGW-1:0] rs1,
  input  logic            rs1_en,
  input  logic [REGW-1:0] rs2,
  input  logic            rs2_en,
  input  logic [REGW-1:0] rd,
  input  logic            rd_en,
  output logic            raw,
  output logic            waw
);

  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_eff;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] set_mask;

  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    if (wb_v)
      wb_mask[wb_rd] = 1'b1;
    if (set_v && rd_en && (rd != '0))
      set_mask[rd] = 1'b1;
  end

  assign sb_eff = sb & ~wb_mask;

  // x0 is never set, so sb[0] stays at its reset value of 0
  assign raw = (rs1_en && (rs1 != '0) && sb_eff[rs1])
            || (rs2_en && (rs2 != '0) && sb_eff[rs2]);
  assign waw = rd_en && (rd != '0) && sb_eff[rd];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sb <= '0;
    else
      sb <= sb_eff | set_mask;
  end

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: hazard check, long-unit occupancy and
// post-redirect squash window between decode and execute.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int NREG      = DEF_NREG,
  parameter int REGW      = DEF_REGW,
  parameter int LONG_LAT  = DEF_LONG_LAT,
  parameter int FLUSH_CYC = DEF_FLUSH_CYC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_v_i,
  input  logic [REGW-1:0] dec_rs1_i,
  input  logic [REGW-1:0] dec_rs2_i,
  input  logic            dec_rs1_en_i,
  input  logic            dec_rs2_en_i,
  input  logic [REGW-1:0] dec_rd_i,
  input  logic            dec_rd_en_i,
  input  logic            dec_long_i,
  input  logic            wb_v_i,
  input  logic [REGW-1:0] wb_rd_i,
  input  logic            redirect_i,
  input  logic            ex_stall_i,
  output logic            issue_o,
  output logic            stall_o,
  output logic            flush_o,
  output logic            long_busy_o
);

  localparam int LW = $clog2(LONG_LAT + 1);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam logic [LW-1:0] LCNT_LOAD = LW'(LONG_LAT);
  localparam logic [FW-1:0] FCNT_LOAD = FW'(FLUSH_CYC);

  state_t        state;
  state_t        state_nxt;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_nxt;
  logic [LW-1:0] lcnt;
  logic [LW-1:0] lcnt_nxt;

  logic raw;
  logic waw;
  logic hazard;
  logic issue;

  issue_ctrl_scoreboard #(
    .NREG (NREG),
    .REGW (REGW)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .wb_v   (wb_v_i),
    .wb_rd  (wb_rd_i),
    .set_v  (issue),
    .rs1    (dec_rs1_i),
    .rs1_en (dec_rs1_en_i),
    .rs2    (dec_rs2_i),
    .rs2_en (dec_rs2_en_i),
    .rd     (dec_rd_i),
    .rd_en  (dec_rd_en_i),
    .raw    (raw),
    .waw    (waw)
  );

  assign hazard = raw || waw || (dec_long_i && (lcnt != '0));

  // Gating with rst keeps outputs low while reset is held
  assign issue = rst && dec_v_i && !hazard && !ex_stall_i
              && !redirect_i && (state == ST_RUN);

  assign issue_o     = issue;
  assign flush_o     = (state == ST_FLUSH);
  assign stall_o     = rst && dec_v_i && !issue && !flush_o;
  assign long_busy_o = (lcnt != '0);

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    unique case (state)
      ST_RUN: begin
        if (redirect_i) begin
          state_nxt = ST_FLUSH;
          fcnt_nxt  = FCNT_LOAD;
        end
      end
      ST_FLUSH: begin
        if (redirect_i) begin
          fcnt_nxt = FCNT_LOAD;
        end else if (fcnt <= FW'(1)) begin
          state_nxt = ST_RUN;
          fcnt_nxt  = '0;
        end else begin
          fcnt_nxt = fcnt - FW'(1);
        end
      end
      default: begin
        state_nxt = ST_RUN;
        fcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    lcnt_nxt = lcnt;
    unique case (1'b1)
      issue && dec_long_i: lcnt_nxt = LCNT_LOAD;
      lcnt != '0:          lcnt_nxt = lcnt - LW'(1);
      default:             lcnt_nxt = lcnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
      fcnt  <= '0;
      lcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      lcnt  <= lcnt_nxt;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: scoreboard, long unit, flush window, reset.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic       dec_v_i;
  logic [4:0] dec_rs1_i;
  logic [4:0] dec_rs2_i;
  logic       dec_rs1_en_i;
  logic       dec_rs2_en_i;
  logic [4:0] dec_rd_i;
  logic       dec_rd_en_i;
  logic       dec_long_i;
  logic       wb_v_i;
  logic [4:0] wb_rd_i;
  logic       redirect_i;
  logic       ex_stall_i;
  logic       issue_o;
  logic       stall_o;
  logic       flush_o;
  logic       long_busy_o;
  logic [3:0] outs;

  int errors = 0;
  int checks = 0;

  issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .dec_v_i      (dec_v_i),
    .dec_rs1_i    (dec_rs1_i),
    .dec_rs2_i    (dec_rs2_i),
    .dec_rs1_en_i (dec_rs1_en_i),
    .dec_rs2_en_i (dec_rs2_en_i),
    .dec_rd_i     (dec_rd_i),
    .dec_rd_en_i  (dec_rd_en_i),
    .dec_long_i   (dec_long_i),
    .wb_v_i       (wb_v_i),
    .wb_rd_i      (wb_rd_i),
    .redirect_i   (redirect_i),
    .ex_stall_i   (ex_stall_i),
    .issue_o      (issue_o),
    .stall_o      (stall_o),
    .flush_o      (flush_o),
    .long_busy_o  (long_busy_o)
  );

  assign outs = {issue_o, stall_o, flush_o, long_busy_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    dec_v_i      = 1'b0;
    dec_rs1_i    = '0;
    dec_rs2_i    = '0;
    dec_rs1_en_i = 1'b0;
    dec_rs2_en_i = 1'b0;
    dec_rd_i     = '0;
    dec_rd_en_i  = 1'b0;
    dec_long_i   = 1'b0;
    wb_v_i       = 1'b0;
    wb_rd_i      = '0;
    redirect_i   = 1'b0;
    ex_stall_i   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    dec_v_i     = 1'b1;
    dec_rd_en_i = 1'b1;
    dec_rd_i    = 5'd4;
    dec_long_i  = 1'b1;
    tick();
    tick();
    smp();
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs: got %b want %b", outs, 4'b0000);
    end
    checks++;
    if (dut.u_sb.sb !== 32'h0) begin
      errors++;
      $display("FAIL reset_sb: got %h want %h", dut.u_sb.sb, 32'h0);
    end
    idle();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_indep();
    for (int i = 1; i <= 5; i++) begin
      idle();
      dec_v_i     = 1'b1;
      dec_rd_en_i = 1'b1;
      dec_rd_i    = 5'(i);
      smp();
      checks++;
      if (outs !== 4'b1000) begin
        errors++;
        $display("FAIL indep_%0d: got %b want %b", i, outs, 4'b1000);
      end
      tick();
    end
    idle();
    smp();
    checks++;
    if (dut.u_sb.sb !== 32'h3E) begin
      errors++;
      $display("FAIL indep_sb: got %h want %h", dut.u_sb.sb, 32'h3E);
    end
    tick();
    for (int i = 1; i <= 5; i++) begin
      wb_v_i  = 1'b1;
      wb_rd_i = 5'(i);
      tick();
    end
    idle();
    smp();
    checks++;
    if (dut.u_sb.sb !== 32'h0) begin
      errors++;
      $display("FAIL indep_clr: got %h want %h", dut.u_sb.sb, 32'h0);
    end
    tick();
  endtask

  task automatic test_raw();
    idle();
    dec_v_i     = 1'b1;
    dec_rd_en_i = 1'b1;
    dec_rd_i    = 5'd3;
    smp();
    checks++;
    if (outs !== 4'b1000) begin
      errors++;
      $display("FAIL raw_prod: got %b want %b", outs, 4'b1000);
    end
    tick();
    dec_rs1_i    = 5'd3;
    dec_rs1_en_i = 1'b1;
    dec_rd_i     = 5'd6;
    for (int k = 1; k <= 3; k++) begin
      smp();
      checks++;
      if (outs !== 4'b0100) begin
        errors++;
        $display("FAIL raw_stall_%0d: got %b want %b", k, outs, 4'b0100);
      end
      tick();
    end
    wb_v_i  = 1'b1;
    wb_rd_i = 5'd3;
    smp();
    checks++;
    if (outs !== 4'b1000) begin
      errors++;
      $display("FAIL raw_bypass: got %b want %b", outs, 4'b1000);
    end
    tick();
    idle();
    smp();
    checks++;
    if (dut.u_sb.sb !== 32'h40) begin
      errors++;
      $display("FAIL raw_sb: got %h want %h", dut.u_sb.sb, 32'h40);
    end
    wb_v_i  = 1'b1;
    wb_rd_i = 5'd6;
    tick();
    idle();
  endtask

  task automatic test_x0();
    idle();
    dec_v_i      = 1'b1;
    dec_rd_en_i  = 1'b1;
    dec_rs1_en_i = 1'b1;
    dec_rs2_en_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      smp();
      checks++;
      if (outs !== 4'b1000) begin
        errors++;
        $display("FAIL x0_%0d: got %b want %b", k, outs, 4'b1000);
      end
      tick();
    end
    idle();
    smp();
    checks++;
    if (dut.u_sb.sb !== 32'h0) begin
      errors++;
      $display("FAIL x0_sb: got %h want %h", dut.u_sb.sb, 32'h0);
    end
    tick();
  endtask

  task automatic test_long();
    idle();
    dec_v_i    = 1'b1;
    dec_long_i = 1'b1;
    smp();
    checks++;
    if (outs !== 4'b1000) begin
      errors++;
      $display("FAIL long_first: got %b want %b", outs, 4'b1000);
    end
    tick();
    for (int k = 1; k <= 8; k++) begin
      smp();
      checks++;
      if (outs !== 4'b0101) begin
        errors++;
        $display("FAIL long_busy_%0d: got %b want %b", k, outs, 4'b0101);
      end
      tick();
    end
    smp();
    checks++;
    if (outs !== 4'b1000) begin
      errors++;
      $display("FAIL long_second: got %b want %b", outs, 4'b1000);
    end
    tick();
    idle();
    repeat (8) tick();
    smp();
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("FAIL long_drain: got %b want %b", outs, 4'b0000);
    end
    tick();
  endtask

  task automatic test_ex_stall();
    idle();
    dec_v_i     = 1'b1;
    dec_rd_en_i = 1'b1;
    dec_rd_i    = 5'd11;
    ex_stall_i  = 1'b1;
    smp();
    checks++;
    if (outs !== 4'b0100) begin
      errors++;
      $display("FAIL exstall_hold: got %b want %b", outs, 4'b0100);
    end
    tick();
    ex_stall_i = 1'b0;
    smp();
    checks++;
    if (outs !== 4'b1000) begin
      errors++;
      $display("FAIL exstall_go: got %b want %b", outs, 4'b1000);
    end
    tick();
    idle();
    wb_v_i  = 1'b1;
    wb_rd_i = 5'd11;
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    dec_v_i     = 1'b1;
    dec_rd_en_i = 1'b1;
    dec_rd_i    = 5'd12;
    tick();
    wb_v_i  = 1'b1;
    wb_rd_i = 5'd12;
    smp();
    checks++;
    if (outs !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_waw_bypass: got %b want %b", outs, 4'b1000);
    end
    tick();
    idle();
    smp();
    checks++;
    if (dut.u_sb.sb !== 32'h1000) begin
      errors++;
      $display("FAIL b2b_set_wins: got %h want %h", dut.u_sb.sb, 32'h1000);
    end
    wb_v_i  = 1'b1;
    wb_rd_i = 5'd12;
    tick();
    idle();
  endtask

  task automatic test_redirect();
    logic [3:0] exp1 [4];
    logic [3:0] exp2 [5];
    exp1 = '{4'b0100, 4'b0010, 4'b0010, 4'b1000};
    exp2 = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    idle();
    dec_v_i     = 1'b1;
    dec_rd_en_i = 1'b1;
    dec_rd_i    = 5'd7;
    for (int k = 0; k < 4; k++) begin
      redirect_i = (k == 0);
      smp();
      checks++;
      if (outs !== exp1[k]) begin
        errors++;
        $display("FAIL redir_a%0d: got %b want %b", k, outs, exp1[k]);
      end
      tick();
    end
    idle();
    wb_v_i  = 1'b1;
    wb_rd_i = 5'd7;
    tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      redirect_i = (k <= 1);
      smp();
      checks++;
      if (outs !== exp2[k]) begin
        errors++;
        $display("FAIL redir_b%0d: got %b want %b", k, outs, exp2[k]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    dec_v_i     = 1'b1;
    dec_rd_en_i = 1'b1;
    dec_rd_i    = 5'd9;
    tick();
    idle();
    redirect_i = 1'b1;
    tick();
    idle();
    dec_v_i     = 1'b1;
    dec_rd_en_i = 1'b1;
    dec_rd_i    = 5'd10;
    smp();
    checks++;
    if (outs !== 4'b0010 || dut.u_sb.sb !== 32'h200) begin
      errors++;
      $display("FAIL arst_pre: got %b/%h want %b/%h",
               outs, dut.u_sb.sb, 4'b0010, 32'h200);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("FAIL arst_outs: got %b want %b", outs, 4'b0000);
    end
    tick();
    tick();
    rst = 1'b1;
    smp();
    checks++;
    if (dut.u_sb.sb !== 32'h0 || dut.state !== ST_RUN) begin
      errors++;
      $display("FAIL arst_state: got %h/%b want %h/%b",
               dut.u_sb.sb, dut.state, 32'h0, ST_RUN);
    end
    checks++;
    if (outs !== 4'b1000) begin
      errors++;
      $display("FAIL arst_resume: got %b want %b", outs, 4'b1000);
    end
    tick();
    idle();
    wb_v_i  = 1'b1;
    wb_rd_i = 5'd10;
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_indep();
    test_raw();
    test_x0();
    test_long();
    test_ex_stall();
    test_back_to_back();
    test_redirect();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
